multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/ctrl_pkg.sv | 42 ++++
 rtl/op_decode.sv | 27 ++
 rtl/multicycle_control.sv | 159 +++++++++++++++
 tb/tb_multicycle_control.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: opcodes, FSM states,
// PC source encodings and the instruction class bundle from op_decode.
package ctrl_pkg;

    localparam logic [5:0] OP_ANDR = 6'b100000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_JR   = 6'b001000;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_NORR = 6'b100110;
    localparam logic [5:0] OP_NORI = 6'b001110;
    localparam logic [5:0] OP_NOTR = 6'b000100;
    localparam logic [5:0] OP_BLEU = 6'b010000;
    localparam logic [5:0] OP_ROLV = 6'b000000;
    localparam logic [5:0] OP_RORV = 6'b000010;

    localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_RS     = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    // At most one flag is set; all clear means the opcode is illegal.
    typedef struct packed {
        logic rtype;
        logic nori;
        logic load;
        logic store;
        logic branch;
        logic jump_reg;
        logic jump_link;
    } op_class_t;

endpackage

// File: rtl/op_decode.sv
// Combinational opcode classifier: maps ir[31:26] onto one-hot class flags
// and raises illegal for any opcode outside the supported set.
module op_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  op_class,
    output logic       illegal
);

    // Classify the opcode; anything unlisted falls through to illegal.
    always_comb begin
        op_class = '0;
        illegal  = 1'b0;
        case (opcode)
            OP_ANDR, OP_NORR, OP_NOTR, OP_ROLV, OP_RORV: op_class.rtype     = 1'b1;
            OP_NORI:                                     op_class.nori      = 1'b1;
            OP_LW:                                       op_class.load      = 1'b1;
            OP_SW:                                       op_class.store     = 1'b1;
            OP_BLEU:                                     op_class.branch    = 1'b1;
            OP_JR:                                       op_class.jump_reg  = 1'b1;
            OP_JAL:                                      op_class.jump_link = 1'b1;
            default:                                     illegal            = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor control unit: owns the instruction register, the
// sticky illegal-opcode flag and the IDLE/FETCH/DECODE/EXEC/MEM/WB sequencer.
// Control outputs are decoded from the current state and ir; the memory
// handshake and the branch flag qualify the few outputs that must react
// within the same cycle.
module multicycle_control
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        alu_le,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [4:0]  alu_ctrl,
    output logic        alu_src,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        link,
    output logic        reg_we,
    output logic [31:0] ir,
    output logic        instr_done,
    output logic        illegal_op
);

    state_t    state;
    op_class_t cls;
    logic      op_illegal;

    op_decode u_op_decode (
        .opcode   (ir[31:26]),
        .op_class (cls),
        .illegal  (op_illegal)
    );

    // Sequencer, instruction register and sticky illegal flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ir         <= '0;
            illegal_op <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_FETCH;
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        ir    <= mem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (op_illegal) begin
                        illegal_op <= 1'b1;
                        state      <= S_FETCH;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (cls.rtype || cls.nori) begin
                        state <= S_WB;
                    end else if (cls.load || cls.store) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state <= cls.load ? S_WB : S_FETCH;
                    end
                end
                S_WB: begin
                    state <= S_FETCH;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Control decode; ir is zero whenever the sequencer sits in IDLE, so alu_ctrl is too.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_SEQ;
        alu_ctrl   = ir[31:27];
        alu_src    = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        link       = 1'b0;
        reg_we     = 1'b0;
        instr_done = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_SEQ;
                end
            end
            S_DECODE: begin
                instr_done = op_illegal;
            end
            S_EXEC: begin
                if (cls.nori || cls.load || cls.store) begin
                    alu_src = 1'b1;
                end
                if (cls.branch) begin
                    pc_write   = alu_le;
                    pc_src     = PC_SRC_BRANCH;
                    instr_done = 1'b1;
                end
                if (cls.jump_reg) begin
                    pc_write   = 1'b1;
                    pc_src     = PC_SRC_RS;
                    instr_done = 1'b1;
                end
                if (cls.jump_link) begin
                    pc_write   = 1'b1;
                    pc_src     = PC_SRC_JUMP;
                    reg_we     = 1'b1;
                    link       = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = cls.store;
                if (cls.store && mem_ready) begin
                    instr_done = 1'b1;
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                instr_done = 1'b1;
                reg_dst    = cls.rtype;
                mem_to_reg = cls.load;
            end
            default: begin
                alu_ctrl = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. The stimulus process plays the
// memory side of each instruction and queues the hand-computed retire
// profile; a monitor accumulates per-instruction activity and compares it
// against the queue head on every instr_done pulse.
module tb_multicycle_control;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        alu_le;
    logic        mem_req;
    logic        mem_we;
    logic        iord;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic [4:0]  alu_ctrl;
    logic        alu_src;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        link;
    logic        reg_we;
    logic [31:0] ir;
    logic        instr_done;
    logic        illegal_op;

    int total = 0;
    int bad   = 0;

    // One directed vector: memory timing, then the expected per-instruction
    // counts and the values expected on the retire cycle.
    typedef struct {
        int          id;
        logic [31:0] instr;
        int          fetchWait;
        int          memWait;
        int          le;
        int          needsMem;
        int          lat;
        int          regWe;
        int          memWe;
        int          pcW;
        int          memCyc;
        int          aluSrc;
        int          rRegWe;
        int          rMemToReg;
        int          rRegDst;
        int          rLink;
        int          rPcSrc;
        int          rPcWrite;
        int          rIllegal;
    } vec_t;

    vec_t vecs[10];
    vec_t expQ[$];

    multicycle_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .alu_le     (alu_le),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_ctrl   (alu_ctrl),
        .alu_src    (alu_src),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .link       (link),
        .reg_we     (reg_we),
        .ir         (ir),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one instruction through fetch (and memory if needed) and wait for it to retire.
    task automatic applyStimulus(input vec_t v);
        int n;
        bit doneSeen;
        expQ.push_back(v);
        alu_le   = (v.le != 0);
        doneSeen = 1'b0;
        n = 0;
        while (!(mem_req && !iord) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) checkOutput($sformatf("v%0d_fetch_timeout", v.id), 32'd1, 32'd0);
        repeat (v.fetchWait) begin
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        mem_rdata = v.instr;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        if (v.needsMem != 0) begin
            n = 0;
            while (!(mem_req && iord) && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 50) checkOutput($sformatf("v%0d_mem_timeout", v.id), 32'd1, 32'd0);
            repeat (v.memWait) begin
                @(posedge clk); #1;
            end
            mem_ready = 1'b1;
            #1;
            if (instr_done) doneSeen = 1'b1;
            @(posedge clk); #1;
            mem_ready = 1'b0;
        end
        n = 0;
        while (!doneSeen && n < 20) begin
            if (instr_done) doneSeen = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        if (!doneSeen) checkOutput($sformatf("v%0d_retire_timeout", v.id), 32'd1, 32'd0);
    endtask

    // Monitor: track each instruction from its first FETCH cycle and score it at instr_done.
    bit   inInstr = 1'b0;
    int   cyc, nRegWe, nMemWe, nPcW, nMemCyc, nAluSrc, nIrWrite;
    vec_t e;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inInstr = 1'b0;
        end else begin
            if (!inInstr && mem_req && !iord) begin
                inInstr  = 1'b1;
                cyc      = 0;
                nRegWe   = 0;
                nMemWe   = 0;
                nPcW     = 0;
                nMemCyc  = 0;
                nAluSrc  = 0;
                nIrWrite = 0;
            end
            if (inInstr) begin
                cyc++;
                if (reg_we)          nRegWe++;
                if (mem_we)          nMemWe++;
                if (pc_write)        nPcW++;
                if (mem_req && iord) nMemCyc++;
                if (alu_src)         nAluSrc++;
                if (ir_write)        nIrWrite++;
                if (instr_done) begin
                    inInstr = 1'b0;
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_retire", 32'd1, 32'd0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput($sformatf("v%0d_latency", e.id),    cyc,        e.lat);
                        checkOutput($sformatf("v%0d_reg_we_cnt", e.id), nRegWe,     e.regWe);
                        checkOutput($sformatf("v%0d_mem_we_cnt", e.id), nMemWe,     e.memWe);
                        checkOutput($sformatf("v%0d_pc_wr_cnt", e.id),  nPcW,       e.pcW);
                        checkOutput($sformatf("v%0d_mem_cyc", e.id),    nMemCyc,    e.memCyc);
                        checkOutput($sformatf("v%0d_alu_src_cnt", e.id), nAluSrc,   e.aluSrc);
                        checkOutput($sformatf("v%0d_ir_wr_cnt", e.id),  nIrWrite,   32'd1);
                        checkOutput($sformatf("v%0d_ir", e.id),         ir,         e.instr);
                        checkOutput($sformatf("v%0d_alu_ctrl", e.id),   alu_ctrl,   {27'd0, e.instr[31:27]});
                        checkOutput($sformatf("v%0d_ret_reg_we", e.id), reg_we,     e.rRegWe);
                        checkOutput($sformatf("v%0d_ret_mem_to_reg", e.id), mem_to_reg, e.rMemToReg);
                        checkOutput($sformatf("v%0d_ret_reg_dst", e.id), reg_dst,   e.rRegDst);
                        checkOutput($sformatf("v%0d_ret_link", e.id),   link,       e.rLink);
                        checkOutput($sformatf("v%0d_ret_pc_src", e.id), pc_src,     e.rPcSrc);
                        checkOutput($sformatf("v%0d_ret_pc_write", e.id), pc_write, e.rPcWrite);
                        checkOutput($sformatf("v%0d_ret_illegal", e.id), illegal_op, e.rIllegal);
                    end
                end
            end
        end
    end

    // Main sequence: reset checks, directed instructions, reset during a memory wait.
    initial begin
        //            id instr          fw mw le mem lat rWe mWe pcW mCyc aSrc | rRegWe rM2R rDst rLink rPcSrc rPcWr rIll
        vecs[0] = '{0, 32'h8C430004, 0, 0, 0, 1,  5,  1,  0,  1,  1,   1,     1,    1,   0,   0,    0,     0,    0}; // lw
        vecs[1] = '{1, 32'hAC430004, 0, 3, 0, 1,  7,  0,  4,  1,  4,   1,     0,    0,   0,   0,    0,     0,    0}; // sw, 3 waits
        vecs[2] = '{2, 32'h40000010, 0, 0, 1, 0,  3,  0,  0,  2,  0,   0,     0,    0,   0,   0,    1,     1,    0}; // bleu taken
        vecs[3] = '{3, 32'h40000010, 0, 0, 0, 0,  3,  0,  0,  1,  0,   0,     0,    0,   0,   0,    1,     0,    0}; // bleu not taken
        vecs[4] = '{4, 32'h0C000040, 0, 0, 0, 0,  3,  1,  0,  2,  0,   0,     1,    0,   0,   1,    2,     1,    0}; // jal
        vecs[5] = '{5, 32'hFC000000, 0, 0, 0, 0,  2,  0,  0,  1,  0,   0,     0,    0,   0,   0,    0,     0,    0}; // illegal
        vecs[6] = '{6, 32'h80221800, 0, 0, 0, 0,  4,  1,  0,  1,  0,   0,     1,    0,   1,   0,    0,     0,    1}; // andr
        vecs[7] = '{7, 32'h21E00008, 0, 0, 0, 0,  3,  0,  0,  2,  0,   0,     0,    0,   0,   0,    3,     1,    1}; // jr
        vecs[8] = '{8, 32'h38220F0F, 0, 0, 0, 0,  4,  1,  0,  1,  0,   1,     1,    0,   0,   0,    0,     0,    1}; // nori
        vecs[9] = '{9, 32'h00221800, 2, 0, 0, 0,  6,  1,  0,  1,  0,   0,     1,    0,   1,   0,    0,     0,    0}; // rolv, slow fetch

        rst_n     = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        alu_le    = 1'b0;
        #1;
        checkOutput("rst_mem_req",    mem_req,    32'd0);
        checkOutput("rst_ir",         ir,         32'd0);
        checkOutput("rst_illegal_op", illegal_op, 32'd0);
        checkOutput("rst_pc_write",   pc_write,   32'd0);
        checkOutput("rst_instr_done", instr_done, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_held_mem_req", mem_req, 32'd0);
        #2 rst_n = 1'b1;
        #1;
        checkOutput("idle_mem_req", mem_req, 32'd0);
        @(posedge clk); #1;
        checkOutput("first_fetch_mem_req", mem_req, 32'd1);
        checkOutput("first_fetch_iord",    iord,    32'd0);

        for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

        // Start a store, stall it in MEM, then pulse reset between clock edges.
        begin
            int n;
            n = 0;
            while (!(mem_req && !iord) && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            mem_ready = 1'b1;
            mem_rdata = 32'hAC430004;
            @(posedge clk); #1;
            mem_ready = 1'b0;
            mem_rdata = 32'h0;
            n = 0;
            while (!(mem_req && iord) && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            checkOutput("midrst_in_mem_we", mem_we, 32'd1);
            @(posedge clk); #1;
            rst_n = 1'b0;
            #1;
            checkOutput("midrst_mem_req",    mem_req,    32'd0);
            checkOutput("midrst_mem_we",     mem_we,     32'd0);
            checkOutput("midrst_iord",       iord,       32'd0);
            checkOutput("midrst_ir",         ir,         32'd0);
            checkOutput("midrst_illegal_op", illegal_op, 32'd0);
            rst_n = 1'b1;
            #1;
            checkOutput("restart_idle_mem_req", mem_req, 32'd0);
            @(posedge clk); #1;
            checkOutput("restart_fetch_mem_req", mem_req, 32'd1);
            checkOutput("restart_fetch_iord",    iord,    32'd0);
        end

        applyStimulus(vecs[9]);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", expQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Last-resort bound on total run time.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
